// File: rtl/excp_pkg.sv
// Shared trap-controller types: cause codes, FSM encoding, mcause layout.
package excp_pkg;

  localparam logic [4:0] EXC_IFU_MISALGN = 5'd0;
  localparam logic [4:0] EXC_ILEGL       = 5'd2;
  localparam logic [4:0] EXC_EBREAK      = 5'd3;
  localparam logic [4:0] EXC_LD_MISALGN  = 5'd4;
  localparam logic [4:0] EXC_ST_MISALGN  = 5'd6;
  localparam logic [4:0] EXC_ECALL       = 5'd11;

  localparam logic [4:0] IRQ_MSI      = 5'd3;
  localparam logic [4:0] IRQ_MTI      = 5'd7;
  localparam logic [4:0] IRQ_MEI      = 5'd11;
  localparam int         IRQ_LCL_BASE = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_CMT  = 2'd2
  } excp_state_e;

  function automatic int irq_bit(input int xlen);
    return xlen - 1;
  endfunction

endpackage

// File: rtl/excp_irq_arb.sv
// Fixed-priority arbiter: MEI, MSI, MTI, then local lines low to high.
module excp_irq_arb
  import excp_pkg::*;
#(
  parameter int N = 7
) (
  input  logic [N-1:0] req,
  output logic         valid,
  output logic [4:0]   code
);

  function automatic logic [4:0] idx_code(input int i);
    if (i == 0) return IRQ_MEI;
    if (i == 1) return IRQ_MSI;
    if (i == 2) return IRQ_MTI;
    return 5'(IRQ_LCL_BASE + i - 3);
  endfunction

  // Scan downward so the lowest index wins.
  always_comb begin
    valid = 1'b0;
    code  = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid = 1'b1;
        code  = idx_code(i);
      end
    end
  end

endmodule

// File: rtl/excp_ctrl.sv
// Trap controller: picks exception/interrupt, runs flush handshake,
// then pulses CSR commit strobes with the latched trap data.
module excp_ctrl
  import excp_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int LIRQ_NUM    = 4,
  parameter bit VECTORED_EN = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                alu_excp_i_valid,
  output logic                alu_excp_i_ready,
  input  logic [XLEN-1:0]     alu_excp_i_pc,
  input  logic [31:0]         alu_excp_i_instr,
  input  logic [XLEN-1:0]     alu_excp_i_badaddr,
  input  logic                alu_excp_i_ifu_misalgn,
  input  logic                alu_excp_i_ilegl,
  input  logic                alu_excp_i_ebreak,
  input  logic                alu_excp_i_ecall,
  input  logic                alu_excp_i_ld_misalgn,
  input  logic                alu_excp_i_st_misalgn,
  input  logic                ext_irq_r,
  input  logic                sft_irq_r,
  input  logic                tmr_irq_r,
  input  logic [LIRQ_NUM-1:0] lcl_irq_r,
  input  logic                meie_r,
  input  logic                msie_r,
  input  logic                mtie_r,
  input  logic [LIRQ_NUM-1:0] lcl_ie_r,
  input  logic                status_mie_r,
  input  logic [XLEN-1:0]     csr_mtvec_r,
  output logic                excpirq_flush_req,
  input  logic                excpirq_flush_ack,
  output logic [XLEN-1:0]     excpirq_flush_pc,
  output logic [XLEN-1:0]     cmt_epc,
  output logic [XLEN-1:0]     cmt_badaddr,
  output logic [XLEN-1:0]     cmt_cause,
  output logic                cmt_epc_ena,
  output logic                cmt_badaddr_ena,
  output logic                cmt_cause_ena,
  output logic                cmt_status_ena,
  output logic                excp_active
);

  localparam int NREQ = 3 + LIRQ_NUM;

  excp_state_e     state;
  logic            cmt_ena;
  logic [XLEN-1:0] epc_q, cause_q, tval_q;

  logic [NREQ-1:0] irq_req;
  logic            irq_take;
  logic [4:0]      irq_code;

  assign irq_req = {lcl_irq_r & lcl_ie_r,
                    tmr_irq_r & mtie_r,
                    sft_irq_r & msie_r,
                    ext_irq_r & meie_r} & {NREQ{status_mie_r}};

  excp_irq_arb #(.N(NREQ)) u_arb (
    .req   (irq_req),
    .valid (irq_take),
    .code  (irq_code)
  );

  logic            exc_any;
  logic [4:0]      exc_code;
  logic [XLEN-1:0] exc_tval;

  assign exc_any = alu_excp_i_ifu_misalgn | alu_excp_i_ilegl
                 | alu_excp_i_ebreak | alu_excp_i_ecall
                 | alu_excp_i_ld_misalgn | alu_excp_i_st_misalgn;

  always_comb begin
    exc_code = '0;
    exc_tval = '0;
    priority case (1'b1)
      alu_excp_i_ifu_misalgn: begin
        exc_code = EXC_IFU_MISALGN;
        exc_tval = alu_excp_i_badaddr;
      end
      alu_excp_i_ilegl: begin
        exc_code = EXC_ILEGL;
        exc_tval = XLEN'(alu_excp_i_instr);
      end
      alu_excp_i_ebreak: begin
        exc_code = EXC_EBREAK;
        exc_tval = alu_excp_i_pc;
      end
      alu_excp_i_ecall: exc_code = EXC_ECALL;
      alu_excp_i_ld_misalgn: begin
        exc_code = EXC_LD_MISALGN;
        exc_tval = alu_excp_i_badaddr;
      end
      alu_excp_i_st_misalgn: begin
        exc_code = EXC_ST_MISALGN;
        exc_tval = alu_excp_i_badaddr;
      end
      default: ;
    endcase
  end

  logic [XLEN-1:0] cause_n, base, vec_off, target_n;
  logic            use_vec, trap;

  always_comb begin
    cause_n      = '0;
    cause_n[4:0] = exc_any ? exc_code : irq_code;
    if (!exc_any) cause_n[irq_bit(XLEN)] = 1'b1;
    vec_off      = '0;
    vec_off[6:2] = irq_code;
  end

  assign base     = {csr_mtvec_r[XLEN-1:2], 2'b00};
  assign use_vec  = VECTORED_EN && !exc_any
                 && (csr_mtvec_r[1:0] == 2'b01);
  assign target_n = use_vec ? base + vec_off : base;
  assign trap     = (state == S_IDLE) && alu_excp_i_valid
                 && (exc_any || irq_take);

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= S_IDLE;
      cmt_ena          <= 1'b0;
      epc_q            <= '0;
      cause_q          <= '0;
      tval_q           <= '0;
      excpirq_flush_pc <= '0;
      cmt_epc          <= '0;
      cmt_badaddr      <= '0;
      cmt_cause        <= '0;
    end else begin
      cmt_ena <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (trap) begin
            state            <= S_REQ;
            epc_q            <= alu_excp_i_pc;
            cause_q          <= cause_n;
            tval_q           <= exc_any ? exc_tval : '0;
            excpirq_flush_pc <= target_n;
          end
        end
        S_REQ: begin
          if (excpirq_flush_ack) begin
            state       <= S_CMT;
            cmt_ena     <= 1'b1;
            cmt_epc     <= epc_q;
            cmt_badaddr <= tval_q;
            cmt_cause   <= cause_q;
          end
        end
        S_CMT:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign alu_excp_i_ready  = (state == S_IDLE);
  assign excp_active       = (state != S_IDLE);
  assign excpirq_flush_req = (state == S_REQ);
  assign cmt_epc_ena       = cmt_ena;
  assign cmt_badaddr_ena   = cmt_ena;
  assign cmt_cause_ena     = cmt_ena;
  assign cmt_status_ena    = cmt_ena;

endmodule

// File: tb/tb_excp_ctrl.sv
// Directed bench for excp_ctrl; drives and samples on the falling edge.
module tb_excp_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid, ready;
  logic [31:0] pc, instr, badaddr;
  logic        ifu_m, ilegl, ebreak, ecall, ld_m, st_m;
  logic        ext, sft, tmr;
  logic [3:0]  lcl, lcl_ie;
  logic        meie, msie, mtie, mie;
  logic [31:0] mtvec;
  logic        req, ack;
  logic [31:0] fpc, epc, bad, cause;
  logic        epc_e, bad_e, cause_e, stat_e, active;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  excp_ctrl dut (
    .clk                    (clk),
    .rst                    (rst),
    .alu_excp_i_valid       (valid),
    .alu_excp_i_ready       (ready),
    .alu_excp_i_pc          (pc),
    .alu_excp_i_instr       (instr),
    .alu_excp_i_badaddr     (badaddr),
    .alu_excp_i_ifu_misalgn (ifu_m),
    .alu_excp_i_ilegl       (ilegl),
    .alu_excp_i_ebreak      (ebreak),
    .alu_excp_i_ecall       (ecall),
    .alu_excp_i_ld_misalgn  (ld_m),
    .alu_excp_i_st_misalgn  (st_m),
    .ext_irq_r              (ext),
    .sft_irq_r              (sft),
    .tmr_irq_r              (tmr),
    .lcl_irq_r              (lcl),
    .meie_r                 (meie),
    .msie_r                 (msie),
    .mtie_r                 (mtie),
    .lcl_ie_r               (lcl_ie),
    .status_mie_r           (mie),
    .csr_mtvec_r            (mtvec),
    .excpirq_flush_req      (req),
    .excpirq_flush_ack      (ack),
    .excpirq_flush_pc       (fpc),
    .cmt_epc                (epc),
    .cmt_badaddr            (bad),
    .cmt_cause              (cause),
    .cmt_epc_ena            (epc_e),
    .cmt_badaddr_ena        (bad_e),
    .cmt_cause_ena          (cause_e),
    .cmt_status_ena         (stat_e),
    .excp_active            (active)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ens();
    return {28'd0, epc_e, bad_e, cause_e, stat_e};
  endfunction

  task automatic clr();
    valid = 0; ifu_m = 0; ilegl = 0; ebreak = 0; ecall = 0;
    ld_m = 0; st_m = 0; ext = 0; sft = 0; tmr = 0; lcl = '0;
    meie = 0; msie = 0; mtie = 0; lcl_ie = '0; mie = 0; ack = 0;
  endtask

  initial begin
    rst = 1; clr();
    pc = '0; instr = '0; badaddr = '0; mtvec = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", ready, 1);
    chk("rst_req", req, 0);
    chk("rst_active", active, 0);
    chk("rst_fpc", fpc, 0);
    chk("rst_cause", cause, 0);
    chk("rst_ens", ens(), 0);
    rst = 0;

    // ecall, ack in first REQ cycle
    valid = 1; ecall = 1; pc = 32'h8000_0100; mtvec = 32'h8000_0000;
    @(negedge clk);
    clr();
    chk("ecall_req", req, 1);
    chk("ecall_ready", ready, 0);
    chk("ecall_active", active, 1);
    chk("ecall_fpc", fpc, 32'h8000_0000);
    ack = 1;
    @(negedge clk);
    ack = 0;
    chk("ecall_ens", ens(), 32'hF);
    chk("ecall_cause", cause, 11);
    chk("ecall_epc", epc, 32'h8000_0100);
    chk("ecall_tval", bad, 0);
    chk("ecall_cmt_req", req, 0);
    @(negedge clk);
    chk("ecall_done_ready", ready, 1);
    chk("ecall_done_ens", ens(), 0);
    chk("ecall_hold_cause", cause, 11);

    // MTI beats pending lcl[1], vectored
    valid = 1; pc = 32'h0000_0400; mtvec = 32'h8000_0001;
    mie = 1; tmr = 1; mtie = 1; lcl = 4'b0010; lcl_ie = 4'hF;
    @(negedge clk);
    clr();
    chk("mti_fpc", fpc, 32'h8000_001C);
    ack = 1;
    @(negedge clk);
    ack = 0;
    chk("mti_cause", cause, 32'h8000_0007);
    chk("mti_tval", bad, 0);
    chk("mti_epc", epc, 32'h0000_0400);
    @(negedge clk);

    // illegal beats external interrupt; direct target
    valid = 1; ilegl = 1; instr = 32'hFFFF_FFFF; pc = 32'h0000_0500;
    ext = 1; meie = 1; mie = 1;
    @(negedge clk);
    clr();
    chk("ilegl_fpc", fpc, 32'h8000_0000);
    ack = 1;
    @(negedge clk);
    ack = 0;
    chk("ilegl_cause", cause, 2);
    chk("ilegl_tval", bad, 32'hFFFF_FFFF);
    @(negedge clk);

    // global mie off: everything retires
    valid = 1; mie = 0; ext = 1; sft = 1; tmr = 1; lcl = 4'hF;
    meie = 1; msie = 1; mtie = 1; lcl_ie = 4'hF;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("nomie_ready", ready, 1);
      chk("nomie_req", req, 0);
      chk("nomie_ens", ens(), 0);
    end
    clr();

    // load misaligned, ack held off
    valid = 1; ld_m = 1; badaddr = 32'h0000_1003; mtvec = 32'h0000_2000;
    pc = 32'h0000_0600;
    @(negedge clk);
    clr();
    for (int i = 0; i < 5; i++) begin
      chk("ldm_req", req, 1);
      chk("ldm_fpc", fpc, 32'h0000_2000);
      chk("ldm_ready", ready, 0);
      chk("ldm_ens", ens(), 0);
      @(negedge clk);
    end
    chk("ldm_req_late", req, 1);
    ack = 1;
    @(negedge clk);
    ack = 0;
    chk("ldm_ens_cmt", ens(), 32'hF);
    chk("ldm_cause", cause, 4);
    chk("ldm_tval", bad, 32'h0000_1003);
    @(negedge clk);

    // lcl[3] vectored, reset while in REQ
    valid = 1; pc = 32'h0000_0700; mtvec = 32'h8000_0001;
    mie = 1; lcl = 4'b1000; lcl_ie = 4'b1000;
    @(negedge clk);
    valid = 0;
    chk("lcl3_req", req, 1);
    chk("lcl3_fpc", fpc, 32'h8000_004C);
    rst = 1; ack = 1;
    @(negedge clk);
    rst = 0; ack = 0;
    chk("midrst_req", req, 0);
    chk("midrst_ready", ready, 1);
    chk("midrst_active", active, 0);
    chk("midrst_fpc", fpc, 0);
    chk("midrst_cause", cause, 0);
    chk("midrst_ens", ens(), 0);
    @(negedge clk);
    chk("midrst_ens2", ens(), 0);

    // same local interrupt taken to completion
    valid = 1;
    @(negedge clk);
    clr();
    chk("lcl3b_fpc", fpc, 32'h8000_004C);
    ack = 1;
    @(negedge clk);
    ack = 0;
    chk("lcl3b_cause", cause, 32'h8000_0013);
    chk("lcl3b_epc", epc, 32'h0000_0700);
    @(negedge clk);
    chk("lcl3b_ready", ready, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
